// File: rtl/qpsk_rx_pkg.sv
// Shared definitions for the frame receive path: frame field positions,
// the UART transmitter state encoding and the baud divider computation.
// Latency: n/a (package). Backpressure: n/a.
package qpsk_rx_pkg;

  // Field boundaries of the 40-bit frame produced upstream:
  // [39:32] header, [31:8] payload, [7:0] checksum.
  localparam int HDR_MSB = 39;
  localparam int PAY_MSB = 31;
  localparam int PAY_LSB = 8;
  localparam int CHK_LSB = 0;
  localparam int PAY_W   = PAY_MSB - PAY_LSB + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Integer clock cycles per UART bit; no fractional accumulation.
  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Synchronous payload FIFO with first-word fall-through read (dout = head).
// Latency: a push is visible on dout/empty the cycle after it is written.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
//
// Ports: push/din write side, pop/dout read side, full/empty status.
// One extra pointer bit distinguishes full from empty. DEPTH must be a
// power of two and at least 2.
module frame_fifo
  import qpsk_rx_pkg::*;
#(
  parameter int WIDTH = PAY_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  // A full FIFO still accepts a push when the head leaves in the same cycle:
  // the write lands in the slot being vacated.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/frame_uart_tx.sv
// Buffers the 24-bit payload of each valid frame and sends it as three UART bytes, MSB byte first.
// Latency: valid_flag in cycle N -> start bit on tx in cycle N+2 (empty FIFO).
// Backpressure: none upstream; a frame arriving at a full FIFO is dropped and ovf_flag pulses.
//
// Ports: clk, rst (synchronous, active-high), valid_flag/valid_data_i (frame in),
//        tx (serial line, idle high), busy (sending or FIFO non-empty),
//        ovf_flag (one-cycle pulse, registered, the cycle after a dropped frame).
// Build option: define FRAME_UART_PARITY_EN for 8E1 (even parity bit after
// the data bits); otherwise the format is 8N1.
module frame_uart_tx
  import qpsk_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 500000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_flag,
  input  logic [39:0] valid_data_i,
  output logic        tx,
  output logic        busy,
  output logic        ovf_flag
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  tx_state_t        state;
  tx_state_t        state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [1:0]       byte_idx;
  logic [7:0]       shift_reg;   // byte on the wire, shifted out LSB first
  logic [15:0]      pending;     // remaining bytes of the frame, next in [15:8]
  logic             bit_end;
  logic             pop;
  logic             load_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PAY_W-1:0] fifo_dout;
  logic             unused_frame_bits;

  // Header and checksum were checked upstream and are not forwarded.
  assign unused_frame_bits = ^{valid_data_i[HDR_MSB:PAY_MSB+1],
                               valid_data_i[PAY_LSB-1:CHK_LSB]};

  frame_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid_flag),
    .pop   (pop),
    .din   (valid_data_i[PAY_MSB:PAY_LSB]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end   = (baud_cnt == CNT_W'(BAUD_DIV - 1));
  assign load_next = (state == STOP) && bit_end && (byte_idx < 2'd2);
  assign busy      = (state != IDLE) | ~fifo_empty;

`ifdef FRAME_UART_PARITY_EN
  logic par_bit;

  // Even parity is computed when each byte is loaded, before it is shifted.
  always_ff @(posedge clk) begin
    if (rst)            par_bit <= 1'b0;
    else if (pop)       par_bit <= ^fifo_dout[23:16];
    else if (load_next) par_bit <= ^pending[15:8];
  end
`endif

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx         = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        tx = shift_reg[0];
        if (bit_end && bit_cnt == 3'd7) begin
`ifdef FRAME_UART_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef FRAME_UART_PARITY_EN
      PARITY: begin
        tx = par_bit;
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_next = (byte_idx < 2'd2) ? START : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
      pending   <= '0;
      ovf_flag  <= 1'b0;
    end else begin
      state    <= state_next;
      ovf_flag <= valid_flag & fifo_full & ~pop;

      // Both counters restart on every state change; only DATA uses bit_cnt.
      if (state_next != state || state == IDLE) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (bit_end) begin
        baud_cnt <= '0;
        bit_cnt  <= bit_cnt + 3'd1;
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end

      if (state == DATA && bit_end) shift_reg <= shift_reg >> 1;

      if (pop) begin
        shift_reg <= fifo_dout[23:16];
        pending   <= fifo_dout[15:0];
        byte_idx  <= 2'd0;
      end else if (load_next) begin
        shift_reg <= pending[15:8];
        pending   <= {pending[7:0], 8'h00};
        byte_idx  <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_uart_tx.sv
// Bench for frame_uart_tx: a line monitor decodes every UART byte from tx,
// and the main sequence compares it with bytes derived from the pushed frames.
module tb_frame_uart_tx;

  localparam int CLK_FREQ = 500000;
  localparam int BAUD     = 9600;
  localparam int DEPTH    = 4;
  localparam int BD       = CLK_FREQ / BAUD;
`ifdef FRAME_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       stop;
    bit         stable;
    int         t;
  } rx_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_flag = 1'b0;
  logic [39:0] valid_data_i = '0;
  logic        tx;
  logic        busy;
  logic        ovf_flag;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         ovf_cnt = 0;
  rx_t        rx_q[$];
  logic [7:0] exp_q[$];

  frame_uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_flag   (valid_flag),
    .valid_data_i (valid_data_i),
    .tx           (tx),
    .busy         (busy),
    .ovf_flag     (ovf_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ovf_flag === 1'b1) ovf_cnt <= ovf_cnt + 1;
  end

  // Line monitor: one record per complete character, aborted characters dropped.
  initial begin : mon
    rx_t  r;
    bit   aborted;
    logic wave [11*BD];
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        r.t     = cyc;
        wave[0] = tx;
        aborted = 0;
        for (int off = 1; off < NB*BD; off++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1;
            break;
          end
          wave[off] = tx;
        end
        if (!aborted) begin
          r.stable = 1;
          for (int s = 0; s < NB; s++)
            for (int j = 0; j < BD; j++)
              if (wave[s*BD+j] !== wave[s*BD]) r.stable = 0;
          for (int i = 0; i < 8; i++) r.d[i] = wave[(1+i)*BD + BD/2];
          r.p    = wave[9*BD + BD/2];
          r.stop = wave[(NB-1)*BD + BD/2];
          rx_q.push_back(r);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [39:0] rand_frame();
    return {8'($urandom), 24'($urandom), 8'($urandom)};
  endfunction

  // One-cycle valid pulse; accepted frames contribute their payload bytes in send order.
  task automatic pulse(input logic [39:0] frame, input bit accept);
    valid_data_i = frame;
    valid_flag   = 1'b1;
    if (accept) begin
      exp_q.push_back(frame[31:24]);
      exp_q.push_back(frame[23:16]);
      exp_q.push_back(frame[15:8]);
    end
    @(negedge clk);
    valid_flag   = 1'b0;
    valid_data_i = {8'($urandom), $urandom()};
  endtask

  task automatic wait_idle(input string tag, input int bound, output int t_fall);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
    t_fall = cyc;
  endtask

  task automatic check_bytes(input string tag);
    rx_t r;
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      check({tag, "_data"}, r.d, exp_q[0]);
      check({tag, "_stop"}, {31'd0, r.stop}, 32'd1);
      check({tag, "_bit_timing"}, {31'd0, r.stable}, 32'd1);
`ifdef FRAME_UART_PARITY_EN
      check({tag, "_parity"}, {31'd0, r.p}, {31'd0, ^exp_q[0]});
`endif
      void'(exp_q.pop_front());
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin : main
    int         c;
    int         tf;
    int         n;
    int         ovf0;
    bit         quiet;
    logic [39:0] f;

    // Reset held for three edges.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ovf", {31'd0, ovf_flag}, 32'd0);
    repeat (5) @(negedge clk);

    // Single frame: first-byte latency, byte spacing, frame length.
    c = cyc;
    pulse(40'hCC_17_18_19_14, 1);
    check("single_tx_n1", {31'd0, tx}, 32'd1);
    check("single_busy_n1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("single_tx_n2", {31'd0, tx}, 32'd0);
    wait_idle("single_idle", 4*NB*BD, tf);
    check("single_busy_fall", tf, c + 2 + 3*NB*BD);
    check("single_start_time", rx_q[0].t, c + 2);
    check("single_byte_spacing", rx_q[1].t - rx_q[0].t, NB*BD);
    check_bytes("single");

    // Back-to-back frames: exactly one idle cycle between them.
    repeat (3) @(negedge clk);
    pulse(40'h11_010203_22, 1);
    pulse(40'h33_A5A55A_44, 1);
    wait_idle("b2b_idle", 8*NB*BD, tf);
    check("b2b_frame_gap", rx_q[3].t - rx_q[2].t, NB*BD + 1);
    check("b2b_intra_gap", rx_q[5].t - rx_q[4].t, NB*BD);
    check_bytes("b2b");

    // Randomised bursts that never exceed what the FIFO plus the sender can hold.
    for (int it = 0; it < 3; it++) begin
      ovf0 = ovf_cnt;
      n = $urandom_range(1, DEPTH + 1);
      for (int k = 0; k < n; k++) begin
        pulse(rand_frame(), 1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle("rand_idle", (DEPTH + 2)*3*NB*BD, tf);
      check("rand_no_ovf", ovf_cnt - ovf0, 0);
      check_bytes("rand");
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    // Overflow: one frame in flight plus DEPTH buffered; the next one is dropped.
    ovf0 = ovf_cnt;
    for (int k = 0; k < DEPTH + 2; k++) begin
      pulse(rand_frame(), k <= DEPTH);
      check("ovf_pulse", {31'd0, ovf_flag}, {31'd0, k == DEPTH + 1});
    end
    @(negedge clk);
    check("ovf_one_cycle", {31'd0, ovf_flag}, 32'd0);
    wait_idle("ovf_idle", (DEPTH + 3)*3*NB*BD, tf);
    check("ovf_count", ovf_cnt - ovf0, 1);
    check_bytes("ovf");

    // Reset in the middle of the second byte's data bits.
    repeat (4) @(negedge clk);
    c = cyc;
    f = rand_frame();
    pulse(f, 0);
    n = 0;
    while (cyc < c + 2 + NB*BD + 4*BD && n < 4*NB*BD) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    #1;
    check("rst_sync_busy_held", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    check("rst_mid_bytes_sent", rx_q.size(), 1);
    check("rst_mid_first_byte", rx_q[0].d, f[31:24]);
    rx_q.delete();
    exp_q.delete();
    quiet = 1;
    repeat (3*BD) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) quiet = 0;
    end
    check("rst_mid_line_quiet", {31'd0, quiet}, 32'd1);
    c = cyc;
    pulse(rand_frame(), 1);
    wait_idle("rst_after_idle", 4*NB*BD, tf);
    check("rst_after_start_time", rx_q[0].t, c + 2);
    check("rst_after_len", tf, c + 2 + 3*NB*BD);
    check_bytes("rst_after");

`ifdef FRAME_UART_PARITY_EN
    // Parity build: 0x07 carries parity 1, 0x00 carries parity 0.
    repeat (3) @(negedge clk);
    c = cyc;
    pulse(40'h5A_070000_A5, 1);
    wait_idle("par_idle", 4*NB*BD, tf);
    check("par_frame_len", tf, c + 2 + 3*NB*BD);
    check("par_bit_07", {31'd0, rx_q[0].p}, 32'd1);
    check("par_bit_00", {31'd0, rx_q[1].p}, 32'd0);
    check_bytes("par");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_uart_tx.md
# frame_uart_tx

Receive-side stage directly downstream of `data_valid`. It captures every frame that `data_valid` flags as valid and buffers the 24-bit payload in a small frame FIFO. It then serialises the payload as three 8N1 UART bytes toward the host PC. Frame layout, as produced upstream: [39:32] header, [31:8] three payload bytes, [7:0] checksum.

## Interface
Parameters:
- CLK_FREQ, 500000: system clock frequency in Hz.
- BAUD, 9600: UART bit rate.
- FIFO_DEPTH, 4: frames buffered; must be a power of two, ≥2.

Ports:
- clk  input  1  system clock, same 500 kHz domain as `data_valid`.
- rst  input  1  reset; synchronous, active-high.
- valid_flag  input  1  one-cycle pulse from `data_valid`; qualifies valid_data_i.
- valid_data_i  input  40  complete frame; sampled only when valid_flag=1.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while a frame is being transmitted or the FIFO is non-empty.
- ovf_flag  output  1  one-cycle pulse when an incoming frame is dropped because the FIFO is full.

## Operation
- BAUD_DIV = CLK_FREQ/BAUD, integer division; the default is 52. Every UART bit lasts exactly BAUD_DIV clk cycles.
- Push: when valid_flag=1, valid_data_i[31:8] is written to the FIFO. Header and checksum are discarded because they were already checked upstream.
- Full FIFO plus push without a pop in the same cycle: the frame is dropped, the FIFO is unchanged, and ovf_flag pulses for 1 cycle.
- Simultaneous push and pop with the FIFO full: both are accepted and the occupancy is unchanged.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop, latch the payload into the shift register, set byte_idx=0, go to START.
  - START: tx=0 for BAUD_DIV cycles, then DATA.
  - DATA: 8 bits, LSB first, each lasting BAUD_DIV cycles. Then PARITY if compiled in, otherwise STOP.
  - PARITY: see Configuration.
  - STOP: tx=1 for BAUD_DIV cycles. Then:
    - if byte_idx<2: byte_idx+1, load the next byte, go to START;
    - otherwise go to IDLE.
- Byte order within a frame: payload[23:16] first (frame bits [31:24]), then [15:8], then [7:0].
- Bytes of one frame are sent back-to-back with no idle gap. Between frames there is exactly 1 IDLE cycle with tx=1.
- busy = (state≠IDLE) | FIFO non-empty.

## Timing
- Reset values: tx=1, busy=0, ovf_flag=0, FSM in IDLE, FIFO empty, counters 0.
- rst mid-frame: the next cycle shows tx=1, the FIFO is flushed, and the transmission is abandoned with no remaining bits sent.
- Latency, with an empty FIFO and valid_flag high in cycle N:
  - FIFO non-empty in N+1;
  - IDLE pops at the end of N+1;
  - tx falls in cycle N+2.
- Frame duration:
  - without parity: 3×10×BAUD_DIV = 1560 cycles;
  - with parity: 3×11×BAUD_DIV = 1716 cycles.
- The bit counter and baud counter restart at every state change. There is no fractional-baud accumulation.
- valid_flag pulses closer than one cycle apart are not possible. Consecutive-cycle pulses are legal and each one pushes a frame.

## Configuration
- FRAME_UART_PARITY_EN defined: a PARITY state is inserted after DATA. tx carries the even-parity bit (XOR of the 8 data bits) for BAUD_DIV cycles. Format is 8E1.
- Not defined: no PARITY state and no parity logic. Format is 8N1.

## Structure
- Package `qpsk_rx_pkg` holds:
  - the frame field constants HDR_MSB=39, PAY_MSB=31, PAY_LSB=8, CHK_LSB=0;
  - the FSM state typedef {IDLE, START, DATA, PARITY, STOP};
  - the BAUD_DIV computation function.
- One sub-module, `frame_fifo`: a synchronous FIFO with width 24 and depth FIFO_DEPTH. Ports: push, pop, din, dout, full, empty. It uses an extra pointer bit to distinguish full from empty.
- The top level holds the FSM, baud counter, bit counter, byte index and shift register.

## Test plan
- Reset default: rst high 3 cycles, then low → tx=1, busy=0, ovf_flag=0. Reset is synchronous, so rst asserted between edges takes effect only at the next clk edge.
- Single frame: valid_data_i=40'hCC_17_18_19_14, one valid_flag pulse in cycle N →
  - tx low at N+2;
  - decoded bytes 0x17, 0x18, 0x19, each start bit lasting 52 cycles;
  - busy falls 1560 cycles after N+2.
- Back-to-back frames: two pulses in consecutive cycles (payloads 0x010203, 0xA5A55A) → six bytes in order 01 02 03 A5 A5 5A, with exactly 1 idle cycle between the frames.
- Overflow: 6 pulses during the first frame's transmission with FIFO_DEPTH=4 →
  - the first frame is popped immediately, and 4 more frames are buffered;
  - the 6th pulse asserts ovf_flag for one cycle and its payload is never transmitted.
- Reset mid-frame: rst asserted during the 2nd byte's DATA state → tx=1 the next cycle and busy=0. A later frame transmits correctly from a clean START.
- Parity build (FRAME_UART_PARITY_EN): payload 0x070000 → first byte 0x07 has parity bit 1, and the following 0x00 bytes have parity bit 0. Frame length is 1716 cycles.
